hex_scan_driver: RTL

//  Time-multiplexed driver for the 4-digit common-anode 7-segment display.

---
 rtl/hex_scan_driver.sv | 119 +++++++++++
 1 files changed

// File: rtl/hex_scan_driver.sv
// Four-digit multiplexed hex driver for a common-anode 7-segment display.
// Frame-aligned shadow register keeps a digit scan from mixing old and new values.
module hex_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        blank_lz,
    input  logic        en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam int            PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [1:0]    scan_idx_q;
    logic [15:0]   pending_q, shadow_q;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          frame_done_q;

    logic          tick;
    logic          boundary;
    logic [15:0]   pending_d;
    logic [15:0]   shadow_d;
    logic [15:0]   disp_word;
    logic [3:0]    nibble;
    logic [3:0]    upper_nz;
    logic          blank_dig;
    logic [6:0]    seg_d;

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = en && (presc_q == LAST);
        boundary  = tick && (scan_idx_q == 2'd0);
        pending_d = load ? value : pending_q;
        // A load landing on the frame-boundary tick bypasses straight into the shadow.
        disp_word = boundary ? pending_d : shadow_q;
        shadow_d  = boundary ? pending_d : shadow_q;

        case (scan_idx_q)
            2'd0:    nibble = disp_word[3:0];
            2'd1:    nibble = disp_word[7:4];
            2'd2:    nibble = disp_word[11:8];
            default: nibble = disp_word[15:12];
        endcase

        // upper_nz[k]: some nibble at position k or above is non-zero; digit 0 always shown.
        upper_nz[3] = |disp_word[15:12];
        upper_nz[2] = upper_nz[3] | (|disp_word[11:8]);
        upper_nz[1] = upper_nz[2] | (|disp_word[7:4]);
        upper_nz[0] = 1'b1;

        blank_dig = blank_lz && !upper_nz[scan_idx_q];
        seg_d     = blank_dig ? 7'h7F : ~enc(nibble);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            scan_idx_q   <= 2'd0;
            pending_q    <= 16'h0000;
            shadow_q     <= 16'h0000;
            an_q         <= 4'b1111;
            seg_q        <= 7'h7F;
            frame_done_q <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            frame_done_q <= 1'b0;
            if (!en) begin
                presc_q    <= '0;
                scan_idx_q <= 2'd0;
                an_q       <= 4'b1111;
                seg_q      <= 7'h7F;
            end else begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    an_q         <= ~(4'b0001 << scan_idx_q);
                    seg_q        <= seg_d;
                    scan_idx_q   <= scan_idx_q + 2'd1;
                    frame_done_q <= (scan_idx_q == 2'd3);
                end
            end
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule
